// File: rtl/l2_dirty_flush_ctrl_if.sv
// l2_dirty_flush_ctrl_if: check-array, writeback and control signals of the L2 dirty flush controller.
interface l2_dirty_flush_ctrl_if #(parameter int IDX_W = 7);
    logic             flush_req;
    logic             cache_busy;
    logic [IDX_W-1:0] scan_index;
    logic             valid_check;
    logic             dirty_check;
    logic             wb_req;
    logic [IDX_W-1:0] wb_index;
    logic             wb_ack;
    logic             dirty_clear;
    logic             flush_busy;
    logic             flush_done;
    logic [IDX_W:0]   wb_count;
    modport master (
        input  flush_req, cache_busy, valid_check, dirty_check, wb_ack,
        output scan_index, wb_req, wb_index, dirty_clear, flush_busy, flush_done, wb_count
    );
    modport slave (
        output flush_req, cache_busy, valid_check, dirty_check, wb_ack,
        input  scan_index, wb_req, wb_index, dirty_clear, flush_busy, flush_done, wb_count
    );
endinterface

// File: rtl/l2_dirty_flush_ctrl.sv
// l2_dirty_flush_ctrl: scans every L2 line, writes back valid+dirty lines and clears their dirty bits.
module l2_dirty_flush_ctrl #(
    parameter int CHECK_LINE = 128,
    parameter int IDX_W      = $clog2(CHECK_LINE)
) (
    input logic                   clk,
    input logic                   rst_n,
    l2_dirty_flush_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, SCAN, WRITEBACK, CLEAR, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHECK_LINE - 1);
    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [IDX_W:0]   cnt, cnt_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.flush_req) begin
                state_nx = SCAN;
                idx_nx   = '0;
                cnt_nx   = '0;
            end
            SCAN: if (!bus.cache_busy) begin
                if (bus.valid_check && bus.dirty_check) state_nx = WRITEBACK;
                else if (idx == LAST) state_nx = DONE;
                else idx_nx = idx + 1'b1;
            end
            WRITEBACK: if (bus.wb_ack) begin
                cnt_nx   = cnt + 1'b1;
                state_nx = CLEAR;
            end
            CLEAR: begin
                state_nx = (idx == LAST) ? DONE : SCAN;
                idx_nx   = (idx == LAST) ? idx : idx + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    // every output decodes from registered state, so reset drops them asynchronously
    assign bus.scan_index  = idx;
    assign bus.wb_index    = idx;
    assign bus.wb_req      = state == WRITEBACK;
    assign bus.dirty_clear = state == CLEAR;
    assign bus.flush_busy  = state != IDLE;
    assign bus.flush_done  = state == DONE;
    assign bus.wb_count    = cnt;
endmodule

// File: tb/tb_l2_dirty_flush_ctrl.sv
// tb_l2_dirty_flush_ctrl: directed flushes against a valid/dirty array model, checked by an event scoreboard.
module tb_l2_dirty_flush_ctrl;
    localparam int N = 128;
    localparam int IW = 7;
    typedef struct {int kind; int a; int b;} ev_t;
    logic clk = 0;
    logic rst_n = 0;
    logic valid_arr [0:N-1];
    logic dirty_arr [0:N-1];
    ev_t  q[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, start = 0;
    int   ack_delay = 0, wait_cnt = 0;
    int   idx20_cnt = 0, wb_len = 0;
    bit   busy_arm = 0, prev_req = 0;
    l2_dirty_flush_ctrl_if #(.IDX_W(IW)) bus();
    l2_dirty_flush_ctrl #(.CHECK_LINE(N)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign bus.valid_check = valid_arr[bus.scan_index];
    assign bus.dirty_check = dirty_arr[bus.scan_index];
    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    function automatic void push(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        q.push_back(e);
    endfunction
    // kinds: 0 wb_req start (a=index), 1 dirty_clear (a=index, b=wb_req length), 2 done (a=cycle, b=wb_count)
    task automatic expect_event(input int kind, input int a, input int b);
        ev_t e;
        if (q.size() == 0) begin
            check($sformatf("unexpected_event_kind%0d", kind), 1, 0);
            return;
        end
        e = q.pop_front();
        check("event_kind", kind, e.kind);
        check($sformatf("event%0d_a", kind), a, e.a);
        if (kind != 0) check($sformatf("event%0d_b", kind), b, e.b);
    endtask
    initial begin
        bus.wb_ack = 0;
        forever begin
            @(negedge clk);
            if (bus.wb_req) begin
                bus.wb_ack = (wait_cnt == ack_delay);
                wait_cnt++;
            end else begin
                bus.wb_ack = 0;
                wait_cnt = 0;
            end
        end
    end
    initial begin
        bus.cache_busy = 0;
        forever begin
            @(negedge clk);
            if (busy_arm && bus.flush_busy && bus.scan_index == 20) begin
                busy_arm = 0;
                bus.cache_busy = 1;
                repeat (3) @(negedge clk);
                bus.cache_busy = 0;
            end
        end
    end
    initial forever begin
        @(posedge clk);
        if (bus.dirty_clear) dirty_arr[bus.scan_index] = 1'b0;
    end
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_req = 0;
            wb_len = 0;
        end else begin
            if (bus.flush_busy && bus.scan_index == 20) idx20_cnt++;
            if (bus.wb_req) wb_len++;
            if (bus.wb_req && prev_req) check("wb_index_stable", int'(bus.wb_index), int'(dut.idx));
            if (bus.wb_req && !prev_req) expect_event(0, int'(bus.wb_index), 0);
            if (bus.dirty_clear) begin
                expect_event(1, int'(bus.scan_index), wb_len);
                wb_len = 0;
            end
            if (bus.flush_done) expect_event(2, cyc - start + 1, int'(bus.wb_count));
            prev_req = bus.wb_req;
        end
    end
    task automatic clear_arrays();
        for (int i = 0; i < N; i++) begin
            valid_arr[i] = 0;
            dirty_arr[i] = 0;
        end
    endtask
    task automatic start_flush();
        @(negedge clk);
        bus.flush_req = 1;
        @(posedge clk);
        #1 start = cyc;
        bus.flush_req = 0;
    endtask
    task automatic wait_done(input string n);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.flush_done) seen = 1;
        end
        check({n, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        check({n, "_queue_empty"}, q.size(), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.flush_req = 0;
        clear_arrays();
        #2;
        check("rst_busy", bus.flush_busy, 0);
        check("rst_wb_req", bus.wb_req, 0);
        check("rst_done", bus.flush_done, 0);
        check("rst_clear", bus.dirty_clear, 0);
        check("rst_index", int'(bus.scan_index), 0);
        check("rst_count", int'(bus.wb_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        // all lines clean
        push(2, 129, 0);
        start_flush();
        wait_done("clean");
        check("clean_count", int'(bus.wb_count), 0);
        // lines 5 and 127, immediate ack
        valid_arr[5] = 1; dirty_arr[5] = 1;
        valid_arr[127] = 1; dirty_arr[127] = 1;
        push(0, 5, 0); push(1, 5, 1); push(0, 127, 0); push(1, 127, 1); push(2, 133, 2);
        start_flush();
        wait_done("two");
        check("two_count", int'(bus.wb_count), 2);
        check("two_dirty5", dirty_arr[5], 0);
        check("two_dirty127", dirty_arr[127], 0);
        check("two_valid5", valid_arr[5], 1);
        check("two_index_hold", int'(bus.scan_index), 127);
        // restart clears count and index; a flush_req while busy is ignored
        clear_arrays();
        push(2, 129, 0);
        start_flush();
        @(negedge clk);
        check("restart_index", int'(bus.scan_index), 0);
        check("restart_count", int'(bus.wb_count), 0);
        repeat (10) @(negedge clk);
        bus.flush_req = 1;
        @(negedge clk);
        bus.flush_req = 0;
        wait_done("repulse");
        repeat (5) @(negedge clk);
        check("repulse_idle", bus.flush_busy, 0);
        // dirty-but-invalid and valid-but-clean lines are skipped
        valid_arr[4] = 1; dirty_arr[3] = 1;
        push(2, 129, 0);
        start_flush();
        wait_done("skip");
        check("skip_count", int'(bus.wb_count), 0);
        check("skip_dirty3", dirty_arr[3], 1);
        // delayed ack plus cache_busy stall
        clear_arrays();
        valid_arr[10] = 1; dirty_arr[10] = 1;
        ack_delay = 5;
        busy_arm = 1;
        idx20_cnt = 0;
        push(0, 10, 0); push(1, 10, 6); push(2, 139, 1);
        start_flush();
        wait_done("stall");
        check("stall_idx20_cycles", idx20_cnt, 4);
        check("stall_dirty10", dirty_arr[10], 0);
        // asynchronous reset during writeback of line 7
        clear_arrays();
        valid_arr[7] = 1; dirty_arr[7] = 1;
        ack_delay = 1000;
        push(0, 7, 0);
        start_flush();
        for (int i = 0; i < 50 && !bus.wb_req; i++) @(negedge clk);
        check("rstwb_req_seen", bus.wb_req, 1);
        check("rstwb_index", int'(bus.wb_index), 7);
        #2 rst_n = 0;
        #1;
        check("rstwb_req", bus.wb_req, 0);
        check("rstwb_busy", bus.flush_busy, 0);
        check("rstwb_clear", bus.dirty_clear, 0);
        check("rstwb_index0", int'(bus.scan_index), 0);
        check("rstwb_count", int'(bus.wb_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("rstwb_idle", bus.flush_busy, 0);
        check("rstwb_queue_empty", q.size(), 0);
        check("rstwb_dirty7", dirty_arr[7], 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_dirty_flush_ctrl.md
Name: l2_dirty_flush_ctrl

Overview:
- Walks every L2 line and writes back each line that is both valid and dirty, then clears that line's dirty bit.
- Consumer and clearer of the L2 valid/dirty check arrays: it reads the check bits through a data-side index and drives the data-side clear.
- Sits between the L2 controller, which starts a flush (fence, context switch or power-down), and the memory writeback path.

Parameters:
- CHECK_LINE, 128, number of L2 lines scanned; power of two, at least 2.
- IDX_W, $clog2(CHECK_LINE), width of the line index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_req  input  1  start pulse; sampled only in IDLE.
- cache_busy  input  1  L2 pipeline owns the check arrays this cycle; the scan stalls.
- scan_index  output  IDX_W  line index presented to the valid and dirty check arrays.
- valid_check  input  1  valid bit at scan_index, combinational, same cycle.
- dirty_check  input  1  dirty bit at scan_index, combinational, same cycle.
- wb_req  output  1  writeback request for line wb_index.
- wb_index  output  IDX_W  line being written back (equals scan_index).
- wb_ack  input  1  writeback accepted; completes the handshake in the cycle wb_req&&wb_ack.
- dirty_clear  output  1  one-cycle pulse that clears the dirty bit at scan_index.
- flush_busy  output  1  high in every state except IDLE.
- flush_done  output  1  one-cycle completion pulse.
- wb_count  output  IDX_W+1  number of lines written back by the current or last flush.

Behaviour:
- Reset: the asynchronous assertion of rst_n forces the following, including mid-flush:
  - state IDLE, scan_index 0, wb_count 0;
  - wb_req, dirty_clear, flush_busy and flush_done all 0;
  - any outstanding writeback is abandoned, so the memory side must also reset.
- States: IDLE, SCAN, WRITEBACK, CLEAR, DONE.
- IDLE:
  - On flush_req=1: go to SCAN, set scan_index to 0, clear wb_count.
  - Otherwise stay.
- SCAN, when cache_busy=1: hold state and index; no outputs change.
- SCAN, when cache_busy=0:
  - If valid_check && dirty_check: go to WRITEBACK.
  - Else, if scan_index == CHECK_LINE-1: go to DONE.
  - Else: increment scan_index and stay in SCAN.
  - A line that is dirty but not valid is skipped.
- WRITEBACK:
  - wb_req=1 and wb_index=scan_index, held stable until wb_ack.
  - On wb_req&&wb_ack: increment wb_count and go to CLEAR.
  - cache_busy is ignored, because the line is already latched.
  - wb_ack outside WRITEBACK is ignored.
- CLEAR:
  - dirty_clear=1 for exactly one cycle, with scan_index unchanged.
  - Then, if scan_index == CHECK_LINE-1: go to DONE.
  - Else: increment scan_index and go to SCAN.
- DONE: flush_done=1 for one cycle, then go to IDLE. wb_count holds its value until the next flush_req is accepted.
- flush_req outside IDLE is ignored; no queueing.
- No wrap-around: the scan ends at CHECK_LINE-1, and scan_index stays at CHECK_LINE-1 through DONE.
- IDLE resets scan_index to 0 only when it accepts flush_req.
- wb_count saturation is impossible: the maximum is CHECK_LINE, which fits in IDX_W+1 bits.
- Latency with all lines clean and cache_busy=0: 1 (IDLE) + CHECK_LINE (SCAN) + 1 (DONE) cycles from accept to the end of the done pulse. flush_done is high in cycle CHECK_LINE+1 after the sampling edge.
- Each written-back line adds (wb_ack wait + 1) WRITEBACK cycles plus 1 CLEAR cycle. With immediate ack this is 2 extra cycles.
- Each cache_busy cycle in SCAN adds 1 cycle.
- All outputs are registered state or decoded from state and registers. There is no combinational path from wb_ack to wb_req.

Test Plan:
- Reset mid-WRITEBACK at line 7 with wb_req=1 → asserting rst_n low immediately drops wb_req, flush_busy and dirty_clear, and the block returns to IDLE with scan_index 0.
- All lines clean, cache_busy=0, flush_req pulsed → flush_done high 129 cycles after the sampling edge, wb_req never asserted, wb_count=0.
- Lines 5 and 127 valid+dirty, wb_ack immediate:
  - wb_req with wb_index=5, then dirty_clear pulses at index 5;
  - wb_req with wb_index=127, then dirty_clear at 127;
  - flush_done at cycle 133; wb_count=2.
- Line 3 dirty but invalid, and line 4 valid but clean → no wb_req, no dirty_clear; wb_count=0.
- Line 10 valid+dirty, wb_ack delayed 5 cycles, cache_busy=1 for 3 cycles at index 20:
  - wb_req stays high with wb_index=10 for 6 cycles;
  - scan_index holds 20 for 3 extra cycles;
  - done at cycle 129+2+5+3.
- flush_req re-pulsed while flush_busy=1 → ignored, only one flush_done; a second flush_req after done restarts at index 0 and clears wb_count.
